proc_pipe_muldiv_xunit: RTL
===========================

// Module: proc_pipe_muldiv_xunit
//
// PURPOSE
// - Elastic, fully pipelined integer multiply unit for the X stage of the
//   5-stage pipelined processor; implements RV32M mul/mulh/mulhsu/mulhu.
// - Sits beside the ALU: X-stage operands and writeback tag in, result to
//   the M-stage writeback mux.
// - Generalised successor of the fixed single-cycle X stage:
//   - parametrised width and depth;
//   - val/rdy back-pressure on both ports;
//   - squash input for branch/jump redirects.
//
// PARAMETERS
// - p_nbits     32  operand and result width
// - p_nstages    4  pipeline depth = latency; 2*p_nbits % p_nstages == 0
// - p_tag_nbits  5  opaque tag carried with each op (rf waddr)
//
// PORTS
// - clk           in   1            clock, rising edge
// - reset         in   1            asynchronous, active-high
// - istream_val   in   1            request valid
// - istream_rdy   out  1            unit accepts request
// - istream_fn    in   2            00 mul, 01 mulh, 10 mulhsu, 11 mulhu
// - istream_a     in   p_nbits      op1 (rs1)
// - istream_b     in   p_nbits      op2 (rs2)
// - istream_tag   in   p_tag_nbits  passed through unchanged
// - ostream_val   out  1            result valid
// - ostream_rdy   in   1            consumer accepts result
// - ostream_res   out  p_nbits      result
// - ostream_tag   out  p_tag_nbits  tag of the op producing ostream_res
// - squash        in   1            discard all in-flight ops
// - busy          out  1            any stage valid (ctrl stall/drain)
//
// BEHAVIOUR
// - Reset (asynchronous, any cycle including mid-operation):
//   - all stage valid bits clear immediately;
//   - ostream_val=0, busy=0, ostream_res=0, ostream_tag=0;
//   - istream_rdy=0 while reset=1, then 1 from the first cycle after release.
// - Datapath:
//   - operands extend to 2*p_nbits: a sign-extends for mulh/mulhsu; b
//     sign-extends for mulh only; otherwise zero-extend;
//   - product is computed mod 2^(2*p_nbits);
//   - stage k adds a*b[slice k]<<offset into a 2*p_nbits accumulator;
//     slice width = 2*p_nbits/p_nstages;
//   - the last stage selects the low half (fn=00) or the high half.
// - Pipeline registers: stage i holds val_i, fn, a_ext, b_ext, acc, tag;
//   stage i+1 is the output register.
// - Stage i advances when val_i && (!val_{i+1} || stage i+1 advances).
//   The output stage advances on ostream_val && ostream_rdy.
// - A stage that does not advance holds its contents; an empty stage may
//   fill.
// - istream_rdy = !reset && !squash && (!val_0 || stage 0 advances).
// - Handshake rules:
//   - a transfer is val&&rdy in the same cycle;
//   - val must not depend combinationally on rdy on either port;
//   - rdy may depend on val.
// - Latency and throughput:
//   - an op accepted at cycle t presents ostream_val at t+p_nstages if no
//     downstream stall;
//   - throughput is 1 op/cycle with ostream_rdy held at 1;
//   - results leave in issue order.
// - ostream_val = val_last && !squash. ostream_res and ostream_tag are
//   driven straight from the output-stage register (no combinational path
//   from the istream ports).
// - squash=1 at a rising edge:
//   - all val bits clear;
//   - a simultaneous ostream handshake is void, because ostream_val is
//     masked;
//   - a simultaneous istream request is not accepted (istream_rdy=0).
// - Pipeline full with ostream_rdy=0:
//   - every stage holds;
//   - istream_rdy=0 with no combinational loop;
//   - output values are stable until accepted.
// - busy = OR of all val bits; the control unit stalls csrw/mngr ops on it.
// - Boundary values:
//   - mul 0x80000000*0xFFFFFFFF gives 0x80000000, mulh gives 0;
//   - no overflow flag, no exception;
//   - tag is never interpreted.
//
// TESTING
// - mul  a=7, b=6, tag=3, ostream_rdy=1
//   -> after 4 cycles val=1, res=0x0000002A, tag=3.
// - mulh a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000; mulhu of the same
//   operands -> 0xFFFFFFFE; mulhsu a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
// - 8 back-to-back ops (a=i, b=i+1, tag=i) with ostream_rdy=1
//   -> one result per cycle from cycle 4, res=i*(i+1), tags 0..7 in order.
// - Back-pressure:
//   - ostream_rdy=0 while 6 ops are offered -> after 4 accepts istream_rdy=0
//     and res/tag hold stable;
//   - ostream_rdy=1 -> results drain in order, nothing dropped or
//     duplicated.
// - Issue 3 ops, squash=1 for one cycle with ostream_val=1
//   -> no handshake, busy=0 next cycle; a new op issued after that returns
//   the correct result 4 cycles later.
// - Reset asserted mid-burst, asynchronous to clk
//   -> ostream_val/busy fall without a clock edge; after release the first
//   op completes correctly.

Source files
------------

// File: rtl/proc_pipe_muldiv_xunit_if.sv
// X-stage multiply unit stream bundle: request stream in, result stream out,
// plus the squash and busy sideband used by the pipeline control unit.
interface proc_pipe_muldiv_xunit_if #(
  parameter int p_nbits     = 32,
  parameter int p_tag_nbits = 5
);
  logic                   istream_val;
  logic                   istream_rdy;
  logic [1:0]             istream_fn;
  logic [p_nbits-1:0]     istream_a;
  logic [p_nbits-1:0]     istream_b;
  logic [p_tag_nbits-1:0] istream_tag;
  logic                   ostream_val;
  logic                   ostream_rdy;
  logic [p_nbits-1:0]     ostream_res;
  logic [p_tag_nbits-1:0] ostream_tag;
  logic                   squash;
  logic                   busy;

  modport slave (
    input  istream_val, istream_fn, istream_a, istream_b, istream_tag,
    input  ostream_rdy, squash,
    output istream_rdy, ostream_val, ostream_res, ostream_tag, busy
  );

  modport master (
    output istream_val, istream_fn, istream_a, istream_b, istream_tag,
    output ostream_rdy, squash,
    input  istream_rdy, ostream_val, ostream_res, ostream_tag, busy
  );
endinterface

// File: rtl/proc_pipe_muldiv_xunit.sv
// Elastic pipelined RV32M multiplier (mul/mulh/mulhsu/mulhu) for the X stage.
// Each stage folds one slice of b into a double-width accumulator; the last register holds the result.
module proc_pipe_muldiv_xunit #(
  parameter int p_nbits     = 32,
  parameter int p_nstages   = 4,
  parameter int p_tag_nbits = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  proc_pipe_muldiv_xunit_if.slave io
);

  localparam int c_w2 = 2 * p_nbits;
  localparam int c_sw = c_w2 / p_nstages;
  localparam int c_ni = p_nstages - 1;

  // intermediate stages 0..c_ni-1
  logic [c_ni-1:0]        val_q, val_d;
  logic [1:0]             fn_q   [c_ni];
  logic [1:0]             fn_d   [c_ni];
  logic [c_w2-1:0]        a_q    [c_ni];
  logic [c_w2-1:0]        a_d    [c_ni];
  logic [c_w2-1:0]        b_q    [c_ni];
  logic [c_w2-1:0]        b_d    [c_ni];
  logic [c_w2-1:0]        acc_q  [c_ni];
  logic [c_w2-1:0]        acc_d  [c_ni];
  logic [p_tag_nbits-1:0] tag_q  [c_ni];
  logic [p_tag_nbits-1:0] tag_d  [c_ni];

  // output stage
  logic                   out_val_q, out_val_d;
  logic [p_nbits-1:0]     res_q, res_d;
  logic [p_tag_nbits-1:0] out_tag_q, out_tag_d;

  logic [p_nstages-1:0]   all_val;
  logic [p_nstages-1:0]   adv;
  logic                   go;
  logic                   in_fire;
  logic [c_w2-1:0]        in_a_ext;
  logic [c_w2-1:0]        in_b_ext;
  logic [c_w2-1:0]        full_prod;

  function automatic logic [c_w2-1:0] ext(input logic [p_nbits-1:0] v, input logic sx);
    return {{p_nbits{sx & v[p_nbits-1]}}, v};
  endfunction

  function automatic logic [c_w2-1:0] pp(input logic [c_w2-1:0] a,
                                         input logic [c_w2-1:0] b,
                                         input int              k);
    logic [c_w2-1:0] s;
    s            = '0;
    s[c_sw-1:0]  = b[k*c_sw +: c_sw];
    return (a * s) << (k * c_sw);
  endfunction

  assign all_val  = {out_val_q, val_q};
  assign in_a_ext = ext(io.istream_a, io.istream_fn[0] ^ io.istream_fn[1]);
  assign in_b_ext = ext(io.istream_b, io.istream_fn == 2'b01);

  // A stage advances if some stage above it is empty or the output is being taken;
  // computed top-down with a running flag so no bit of adv feeds another.
  always_comb begin
    adv               = '0;
    go                = io.ostream_val && io.ostream_rdy;
    adv[p_nstages-1]  = go;
    for (int k = p_nstages - 2; k >= 0; k--) begin
      go     = go || !all_val[k+1];
      adv[k] = all_val[k] && go;
    end
  end

  assign io.istream_rdy = !reset && !io.squash && (!all_val[0] || adv[0]);
  assign in_fire        = io.istream_val && io.istream_rdy;

  assign full_prod = acc_q[c_ni-1] + pp(a_q[c_ni-1], b_q[c_ni-1], c_ni);

  always_comb begin
    val_d     = val_q;
    fn_d      = fn_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    tag_d     = tag_q;
    out_val_d = out_val_q;
    res_d     = res_q;
    out_tag_d = out_tag_q;

    if (in_fire) begin
      val_d[0] = 1'b1;
      fn_d[0]  = io.istream_fn;
      a_d[0]   = in_a_ext;
      b_d[0]   = in_b_ext;
      acc_d[0] = pp(in_a_ext, in_b_ext, 0);
      tag_d[0] = io.istream_tag;
    end else if (adv[0]) begin
      val_d[0] = 1'b0;
    end

    for (int k = 1; k < c_ni; k++) begin
      if (adv[k-1]) begin
        val_d[k] = 1'b1;
        fn_d[k]  = fn_q[k-1];
        a_d[k]   = a_q[k-1];
        b_d[k]   = b_q[k-1];
        acc_d[k] = acc_q[k-1] + pp(a_q[k-1], b_q[k-1], k);
        tag_d[k] = tag_q[k-1];
      end else if (adv[k]) begin
        val_d[k] = 1'b0;
      end
    end

    if (adv[c_ni-1]) begin
      out_val_d = 1'b1;
      res_d     = (fn_q[c_ni-1] == 2'b00) ? full_prod[p_nbits-1:0] : full_prod[c_w2-1:p_nbits];
      out_tag_d = tag_q[c_ni-1];
    end else if (adv[c_ni]) begin
      out_val_d = 1'b0;
    end

    if (io.squash) begin
      val_d     = '0;
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q     <= '0;
      out_val_q <= 1'b0;
      res_q     <= '0;
      out_tag_q <= '0;
      for (int k = 0; k < c_ni; k++) begin
        fn_q[k]  <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        acc_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      val_q     <= val_d;
      fn_q      <= fn_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      tag_q     <= tag_d;
      out_val_q <= out_val_d;
      res_q     <= res_d;
      out_tag_q <= out_tag_d;
    end
  end

  // squash masks the handshake so the consumer never sees a discarded result
  assign io.ostream_val = out_val_q && !io.squash;
  assign io.ostream_res = res_q;
  assign io.ostream_tag = out_tag_q;
  assign io.busy        = |all_val;

endmodule
